// File: rtl/cosine_req_driver_pkg.sv
// Shared definitions for the cosine request driver.
//   - Field widths of a queued job ({x, y}) and its packed entry type.
//   - Driver FSM state encoding.
//   - Q8.8 constant for one (the cosine of angle zero).
package cosine_req_driver_pkg;

    localparam int X_W     = 16;  // angle, Q8.8 unsigned
    localparam int Y_W     = 8;   // term threshold, Q0.8
    localparam int ENTRY_W = X_W + Y_W;

    localparam logic [15:0] Q88_ONE = 16'h0100;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_e;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } req_entry_t;

endpackage

// File: rtl/cosine_req_driver_req_fifo.sv
// Request queue for the cosine driver: DEPTH entries of {x, y}.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   push_i, wdata_i write request and data (ignored while full)
//   pop_i           drop the head entry (ignored while empty)
//   rdata_o         current head entry (valid when not empty)
//   full_o, empty_o queue status
//   count_o         number of stored entries
// A push and a pop in the same cycle while full only pops: the full queue
// refuses the push, which matches req_ready being low in that cycle.
module cdrv_req_fifo
    import cosine_req_driver_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  req_entry_t               wdata_i,
    output req_entry_t               rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    req_entry_t      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            push_ok_s;
    logic            pop_ok_s;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == {CW{1'b0}});
    assign count_o   = count_q;
    assign rdata_o   = mem_q[rd_ptr_q];
    assign push_ok_s = push_i & ~full_o;
    assign pop_ok_s  = pop_i & ~empty_o;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1'b1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_q <= count_q + CW'(1'b1);
                2'b01:   count_q <= count_q - CW'(1'b1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '{x: {X_W{1'b0}}, y: {Y_W{1'b0}}};
            end
        end else if (push_ok_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/cosine_req_driver.sv
// Initiator for the cosine engine. Queues host (x, y) jobs, issues them one
// at a time with a single-cycle eng_start, waits for eng_ready (bounded by
// TIMEOUT_CYC cycles), and holds the Q8.8 answer on a valid/ready port.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   req_valid/req_ready/req_x/y   host job input
//   eng_start/eng_x/eng_y         job issue to the engine
//   eng_ans/eng_ready             engine answer
//   res_valid/res_ready           result handshake to host
//   res_data/res_err              answer (0 with res_err=1 on timeout)
//   busy                          job in flight or queued
// The IDLE->ISSUE edge loads eng_x/eng_y, pops the queue and raises
// eng_start, so the ISSUE cycle is exactly the cycle the engine sees start.
module cosine_req_driver
    import cosine_req_driver_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [X_W-1:0]  req_x,
    input  logic [Y_W-1:0]  req_y,
    output logic            eng_start,
    output logic [X_W-1:0]  eng_x,
    output logic [Y_W-1:0]  eng_y,
    input  logic [15:0]     eng_ans,
    input  logic            eng_ready,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [15:0]     res_data,
    output logic            res_err,
    output logic            busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] TMR_MAX  = {TMR_W{1'b1}};

    state_e            state_q,     state_d;
    logic [TMR_W-1:0]  timer_q,     timer_d;
    logic              eng_start_q, eng_start_d;
    logic [X_W-1:0]    eng_x_q,     eng_x_d;
    logic [Y_W-1:0]    eng_y_q,     eng_y_d;
    logic              res_valid_q, res_valid_d;
    logic [15:0]       res_data_q,  res_data_d;
    logic              res_err_q,   res_err_d;

    logic              push_s;
    logic              pop_s;
    req_entry_t        head_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [CNT_W-1:0]  fifo_count_s;

    assign req_ready = ~fifo_full_s;
    assign push_s    = req_valid & ~fifo_full_s;

    cdrv_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_req_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .wdata_i ('{x: req_x, y: req_y}),
        .rdata_o (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    // Next-state and next-output logic for the issue/wait/hold sequence.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        eng_start_d = 1'b0;
        eng_x_d     = eng_x_q;
        eng_y_d     = eng_y_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_err_d   = res_err_q;
        pop_s       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty_s) begin
                    state_d     = S_ISSUE;
                    eng_start_d = 1'b1;
                    eng_x_d     = head_s.x;
                    eng_y_d     = head_s.y;
                    pop_s       = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                timer_d = {TMR_W{1'b0}};
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // An answer arriving on the timeout cycle is still a good result.
                if (eng_ready) begin
                    res_data_d  = eng_ans;
                    res_err_d   = 1'b0;
                    res_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end else if (timer_q == TMR_LAST) begin
                    res_data_d  = 16'h0000;
                    res_err_d   = 1'b1;
                    res_valid_d = 1'b1;
                    state_d     = S_HOLD;
                end else if (timer_q != TMR_MAX) begin
                    timer_d = timer_q + TMR_W'(1'b1);
                end else begin
                    timer_d = timer_q;
                end
            end
            S_HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    res_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            timer_q     <= {TMR_W{1'b0}};
            eng_start_q <= 1'b0;
            eng_x_q     <= {X_W{1'b0}};
            eng_y_q     <= {Y_W{1'b0}};
            res_valid_q <= 1'b0;
            res_data_q  <= 16'h0000;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            eng_start_q <= eng_start_d;
            eng_x_q     <= eng_x_d;
            eng_y_q     <= eng_y_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_err_q   <= res_err_d;
        end
    end

    assign eng_start = eng_start_q;
    assign eng_x     = eng_x_q;
    assign eng_y     = eng_y_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_err   = res_err_q;
    assign busy      = (state_q != S_IDLE) || (fifo_count_s != {CNT_W{1'b0}});

endmodule

// File: tb/tb_cosine_req_driver.sv
module tb_cosine_req_driver;
    import cosine_req_driver_pkg::*;

    localparam int DEPTH = 4;
    localparam int TMO   = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid, req_ready, eng_start, eng_ready, res_valid, res_ready, res_err, busy;
    logic [15:0] req_x, eng_x, eng_ans, res_data;
    logic [7:0]  req_y, eng_y;

    always #5 clk = ~clk;

    cosine_req_driver #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .eng_start(eng_start), .eng_x(eng_x),
        .eng_y(eng_y), .eng_ans(eng_ans), .eng_ready(eng_ready),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_err(res_err), .busy(busy)
    );

    typedef struct {logic [15:0] x; logic [7:0] y; int lat;} job_t;

    // behavioural model state: queued jobs and the one job in flight
    job_t        jobq[$];
    job_t        cur;
    int          eng_lat_q[$];
    bit          active = 1'b0;
    int          start_cyc = 0, res_cyc = 0, idle_from = 0;
    logic [15:0] exp_data = 16'h0000;
    logic        exp_err = 1'b0;
    bit          e_start, e_rv, e_rr, e_busy;

    int          cyc = 0, n_cmp = 0, n_bad = 0;
    int          req_lat = 0, lat_tmp = 0, n0 = 0, rsel = 0, jl = 0;
    bit          spur = 1'b0, rr_rand = 1'b0, rr_val = 1'b1;
    bit          eng_pend = 1'b0;
    int          eng_due = 0;
    logic [15:0] eng_val = 16'h0000;
    int          n_starts = 0, last_start = 0, last_rise = 0;
    bit          prev_rv = 1'b0;

    // engine's answer for a job: cos(0)=1.0, the 0x0324 angle gives a negative value
    function automatic logic [15:0] ans_of(input logic [15:0] x, input logic [7:0] y);
        if (x == 16'h0000) return Q88_ONE;
        if (x == 16'h0324) return 16'hFF80;
        return x ^ {y, y};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // engine model and host res_ready driver, updated just after each rising edge
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        eng_ready = (eng_pend && cyc == eng_due) || spur;
        eng_ans   = spur ? 16'h7777 : ((eng_pend && cyc == eng_due) ? eng_val : 16'hDEAD);
        res_ready = rr_rand ? ($urandom_range(0, 1) == 1) : rr_val;
    end

    // per-cycle compare against the model, then model/engine bookkeeping
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("rst_req_ready", 32'(req_ready), 32'd1);
            chk("rst_eng_start", 32'(eng_start), 32'd0);
            chk("rst_eng_x", 32'(eng_x), 32'd0);
            chk("rst_eng_y", 32'(eng_y), 32'd0);
            chk("rst_res_valid", 32'(res_valid), 32'd0);
            chk("rst_res_data", 32'(res_data), 32'd0);
            chk("rst_res_err", 32'(res_err), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            jobq.delete();
            eng_lat_q.delete();
            active = 1'b0; idle_from = 0; eng_pend = 1'b0; prev_rv = 1'b0;
        end else begin
            e_rr    = jobq.size() < DEPTH;
            e_busy  = active || (jobq.size() != 0);
            e_start = active && (cyc == start_cyc);
            e_rv    = active && (cyc >= res_cyc);
            chk("req_ready", 32'(req_ready), 32'(e_rr));
            chk("busy", 32'(busy), 32'(e_busy));
            chk("eng_start", 32'(eng_start), 32'(e_start));
            chk("res_valid", 32'(res_valid), 32'(e_rv));
            if (active && cyc >= start_cyc && cyc < res_cyc) begin
                chk("eng_x", 32'(eng_x), 32'(cur.x));
                chk("eng_y", 32'(eng_y), 32'(cur.y));
            end
            if (e_rv) begin
                chk("res_data", 32'(res_data), 32'(exp_data));
                chk("res_err", 32'(res_err), 32'(exp_err));
            end
            if (eng_pend && cyc == eng_due) eng_pend = 1'b0;
            if (eng_start) begin
                n_starts++;
                last_start = cyc;
                if (eng_lat_q.size() > 0) begin
                    lat_tmp = eng_lat_q.pop_front();
                    if (lat_tmp > 0) begin
                        eng_pend = 1'b1;
                        eng_due  = cyc + lat_tmp;
                        eng_val  = ans_of(eng_x, eng_y);
                    end
                end
            end
            if (res_valid && !prev_rv) last_rise = cyc;
            prev_rv = res_valid;
            if (e_rv && res_ready) begin
                active = 1'b0;
                idle_from = cyc + 1;
            end
            if (!active && cyc >= idle_from && jobq.size() > 0) begin
                cur = jobq.pop_front();
                active = 1'b1;
                start_cyc = cyc + 1;
                if (cur.lat >= 1 && cur.lat <= TMO) begin
                    res_cyc = start_cyc + cur.lat + 1;
                    exp_data = ans_of(cur.x, cur.y);
                    exp_err = 1'b0;
                end else begin
                    res_cyc = start_cyc + TMO + 1;
                    exp_data = 16'h0000;
                    exp_err = 1'b1;
                end
            end
            if (req_valid && e_rr) begin
                jobq.push_back('{req_x, req_y, req_lat});
                eng_lat_q.push_back(req_lat);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] x, input logic [7:0] y, input int lat);
        bit got;
        req_x = x; req_y = y; req_lat = lat; req_valid = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            got = req_ready;
            tick();
            if (got) begin
                req_valid = 1'b0;
                return;
            end
        end
        req_valid = 1'b0;
        n_cmp++; n_bad++;
        $display("FAIL push_timeout: got no accept expected accept (cycle %0d)", cyc);
    endtask

    task automatic wait_res_check(input string nm, input int dlt, input logic [15:0] d, input logic e);
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            #1;
            if (res_valid) begin
                chk({nm, "_latency"}, last_rise - last_start, dlt);
                chk({nm, "_data"}, 32'(res_data), 32'(d));
                chk({nm, "_err"}, 32'(res_err), 32'(e));
                tick();
                return;
            end
        end
        n_cmp++; n_bad++;
        $display("FAIL %s_res_timeout: got no res_valid expected res_valid (cycle %0d)", nm, cyc);
        tick();
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 8000; n++) begin
            @(negedge clk);
            #1;
            if (!busy && !res_valid && !eng_pend) begin
                tick();
                return;
            end
        end
        n_cmp++; n_bad++;
        $display("FAIL idle_timeout: got busy expected idle (cycle %0d)", cyc);
        tick();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish expected finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid = 1'b0; req_x = 16'h0000; req_y = 8'h00;
        eng_ready = 1'b0; eng_ans = 16'h0000; res_ready = 1'b1;
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();

        // single job, 20-cycle engine: result 21 cycles after start
        n0 = n_starts;
        push(16'h0000, 8'h01, 20);
        wait_res_check("t1", 21, 16'h0100, 1'b0);
        wait_idle();
        chk("t1_starts", n_starts - n0, 1);

        // back-to-back jobs, results in push order (order checked every cycle by the model)
        n0 = n_starts;
        for (int i = 0; i < 6; i++) push(16'h1000 + 16'(i * 273), 8'(i + 3), 5);
        wait_idle();
        chk("t2_starts", n_starts - n0, 6);

        // engine never answers: timeout error 256 cycles after start
        push(16'h0050, 8'h10, 0);
        wait_res_check("t3", 256, 16'h0000, 1'b1);
        wait_idle();

        // answer on the timeout cycle wins
        push(16'h0000, 8'h01, 255);
        wait_res_check("t3b", 256, 16'h0100, 1'b0);
        wait_idle();

        // host stalls in HOLD: result stable, no new start, queue fills
        rr_val = 1'b0;
        tick(); tick();
        push(16'h1234, 8'h56, 3);
        wait_res_check("t4", 4, 16'h4462, 1'b0);
        n0 = n_starts;
        for (int i = 0; i < 4; i++) push(16'h2000 + 16'(i), 8'(i), 2);
        repeat (50) tick();
        chk("t4_req_ready", 32'(req_ready), 32'd0);
        chk("t4_starts", n_starts - n0, 0);
        chk("t4_res_valid", 32'(res_valid), 32'd1);
        chk("t4_res_data", 32'(res_data), 32'h4462);
        rr_val = 1'b1;
        wait_idle();

        // negative result passes through unchanged
        push(16'h0324, 8'h40, 7);
        wait_res_check("t5", 8, 16'hFF80, 1'b0);
        wait_idle();

        // randomized jobs, latencies and host back-pressure
        rr_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 5)) tick();
            rsel = int'($urandom_range(0, 19));
            if (rsel == 0) jl = 0;
            else if (rsel == 1) jl = 255;
            else jl = int'($urandom_range(1, 30));
            push(16'($urandom), 8'($urandom), jl);
        end
        wait_idle();
        rr_rand = 1'b0;
        rr_val = 1'b1;
        tick();

        // reset during WAIT, spurious eng_ready afterwards: no result ever appears
        push(16'h0100, 8'h20, 50);
        repeat (10) tick();
        n0 = n_starts;
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        spur = 1'b1;
        repeat (3) tick();
        spur = 1'b0;
        repeat (20) tick();
        chk("t6_starts", n_starts - n0, 0);
        chk("t6_res_valid", 32'(res_valid), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
